// File: rtl/program_loader.sv
// Boot-time instruction-memory writer: takes a framed, checksummed byte stream,
// assembles big-endian words, writes them from address 0 and then releases the CPU.
module program_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              cpu_run,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t            state_reg, state_next;
  logic [7:0]        n_hi_reg;
  logic [15:0]       n_reg;
  logic [1:0]        lane_reg;
  logic [31:0]       word_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W:0]   count_reg;
  logic [7:0]        xor_reg;

  logic              xfer;
  logic              start_accept;
  logic              last_word;
  logic [15:0]       n_rx;

  // Outputs are pure decodes of the state register plus datapath flops.
  assign byte_ready = (state_reg == S_HDR_HI) || (state_reg == S_HDR_LO) ||
                      (state_reg == S_DATA)   || (state_reg == S_CHK);
  assign busy       = byte_ready || (state_reg == S_WRITE);
  assign mem_we     = (state_reg == S_WRITE);
  assign cpu_run    = (state_reg == S_DONE);
  assign error      = (state_reg == S_ERROR);
  assign mem_addr   = idx_reg;
  assign mem_wdata  = word_reg;
  assign word_count = count_reg;

  assign xfer         = byte_valid && byte_ready;
  assign start_accept = start && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                  (state_reg == S_ERROR));
  assign n_rx         = {n_hi_reg, byte_data};
  assign last_word    = ((32'(count_reg) + 32'd1) == 32'(n_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (xfer) state_next = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (xfer) begin
          if ({1'b0, n_rx} > DEPTH_L) state_next = S_ERROR;
          else if (n_rx == 16'd0)     state_next = S_CHK;
          else                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer && (lane_reg == 2'd3)) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = last_word ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) state_next = (byte_data == xor_reg) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_hi_reg  <= '0;
      n_reg     <= '0;
      lane_reg  <= '0;
      word_reg  <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      xor_reg   <= '0;
    end else if (start_accept) begin
      // Memory is left untouched; only the per-load bookkeeping restarts.
      lane_reg  <= '0;
      word_reg  <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
      xor_reg   <= '0;
    end else begin
      if (xfer && (state_reg != S_CHK)) begin
        xor_reg <= xor_reg ^ byte_data;
      end
      if (xfer && (state_reg == S_HDR_HI)) begin
        n_hi_reg <= byte_data;
      end
      if (xfer && (state_reg == S_HDR_LO)) begin
        n_reg <= n_rx;
      end
      if (xfer && (state_reg == S_DATA)) begin
        word_reg <= {word_reg[23:0], byte_data};
        lane_reg <= lane_reg + 2'd1;
      end
      if (state_reg == S_WRITE) begin
        count_reg <= count_reg + 1'b1;
        // Hold the index on the final word so it never passes DEPTH-1.
        if (!last_word) idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded bench for program_loader: expected memory writes are queued as
// bytes are driven and checked by a monitor whenever mem_we fires.
module tb_program_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              cpu_run;
  logic              error;
  logic [ADDR_W:0]   word_count;

  program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_run    (cpu_run),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ADDR_W+31:0] exp_q[$];
  logic [ADDR_W+31:0] exp_w;
  logic [31:0]        words[2] = '{32'h01C00007, 32'h01800000};
  logic [7:0]         run_xor;
  bit                 gaps_en = 0;
  bit                 start_noise = 0;
  int                 start_edge;
  int                 chk_edge;

  // Write monitor: every strobe must match the next queued write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        $display("[TB] write addr=%0d data=%h", mem_addr, mem_wdata);
        if ({mem_addr, mem_wdata} !== exp_w) begin
          fails++;
          $display("FAIL write_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   mem_addr, mem_wdata, exp_w[ADDR_W+31:32], exp_w[31:0]);
        end
        tests++;
        if (32'(word_count) !== 32'(exp_w[ADDR_W+31:32])) begin
          fails++;
          $display("FAIL write_count: got word_count=%0d, required %0d", word_count, exp_w[ADDR_W+31:32]);
        end
      end
      tests++;
      if (byte_ready !== 1'b0) begin
        fails++;
        $display("FAIL write_ready: got byte_ready=%b during write, required 0", byte_ready);
      end
    end
  end

  // All tasks enter and leave at posedge+1.
  task automatic send_byte(input logic [7:0] b);
    bit got = 0;
    if (gaps_en) begin
      repeat ($urandom_range(0, 3)) begin
        byte_valid = 1'b0;
        start = start_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    byte_valid = 1'b1;
    byte_data = b;
    run_xor ^= b;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready === 1'b1) got = 1;
      @(posedge clk); #1;
      if (got) break;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL byte_timeout: byte %h not accepted in 50 cycles, required acceptance", b);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_edge = cyc;
    run_xor = 8'h00;
    tests++;
    if ({byte_ready, busy, cpu_run, error} !== 4'b1100 || word_count !== '0) begin
      fails++;
      $display("FAIL start_state: got ready=%b busy=%b run=%b err=%b count=%0d, required 1 1 0 0 0",
               byte_ready, busy, cpu_run, error, word_count);
    end
  endtask

  task automatic load_frame(input int nw, input logic [7:0] chk_ovr, input bit use_ovr, input bit ok);
    logic [7:0] chk;
    do_start();
    send_byte(8'(nw >> 8));
    send_byte(8'(nw));
    for (int w = 0; w < nw; w++) begin
      exp_q.push_back({ADDR_W'(w), words[w]});
      for (int j = 0; j < 4; j++) send_byte(words[w][31-8*j -: 8]);
    end
    chk = use_ovr ? chk_ovr : run_xor;
    send_byte(chk);
    byte_valid = 1'b0;
    chk_edge = cyc;
    $display("[TB] frame n=%0d chk=%h run=%b err=%b count=%0d", nw, chk, cpu_run, error, word_count);
    tests++;
    if ({cpu_run, error, busy} !== {ok, !ok, 1'b0}) begin
      fails++;
      $display("FAIL frame_status: got run=%b err=%b busy=%b, required %b %b 0", cpu_run, error, busy, ok, !ok);
    end
    tests++;
    if (32'(word_count) !== nw) begin
      fails++;
      $display("FAIL frame_count: got %0d, required %0d", word_count, nw);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL frame_writes: got %0d writes missing, required 0", exp_q.size());
      exp_q.delete();
    end
    if (!gaps_en) begin
      tests++;
      if (chk_edge - start_edge !== 3 + 5 * nw) begin
        fails++;
        $display("FAIL frame_latency: got %0d cycles, required %0d", chk_edge - start_edge, 3 + 5 * nw);
      end
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({byte_ready, mem_we, busy, cpu_run, error} !== 5'b0 || word_count !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got ready=%b we=%b busy=%b run=%b err=%b count=%0d, required all 0",
               byte_ready, mem_we, busy, cpu_run, error, word_count);
    end
    rst_n = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h5A;
    repeat (4) begin
      @(posedge clk); #1;
      tests++;
      if ({byte_ready, busy} !== 2'b00) begin
        fails++;
        $display("FAIL idle_valid: got ready=%b busy=%b, required 0 0", byte_ready, busy);
      end
    end
    byte_valid = 1'b0;
    $display("[TB] reset/idle checked");
  endtask

  task automatic test_basic();
    load_frame(2, 8'h00, 0, 1);
  endtask

  task automatic test_bad_chk();
    load_frame(2, 8'h00, 1, 0);
    load_frame(2, 8'h00, 0, 1);
  endtask

  task automatic test_oversize();
    do_start();
    send_byte(8'h04);
    send_byte(8'h01);
    byte_data = 8'hAA;
    tests++;
    if ({error, busy, byte_ready, cpu_run} !== 4'b1000) begin
      fails++;
      $display("FAIL oversize_state: got err=%b busy=%b ready=%b run=%b, required 1 0 0 0",
               error, busy, byte_ready, cpu_run);
    end
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (byte_ready !== 1'b0) begin
        fails++;
        $display("FAIL oversize_ready: got %b, required 0", byte_ready);
      end
    end
    byte_valid = 1'b0;
    $display("[TB] oversize header err=%b", error);
  endtask

  task automatic test_empty();
    load_frame(0, 8'h00, 1, 1);
  endtask

  task automatic test_gaps();
    gaps_en = 1;
    start_noise = 1;
    load_frame(2, 8'h00, 0, 1);
    gaps_en = 0;
    start_noise = 0;
  endtask

  task automatic test_reset_mid();
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    exp_q.push_back({ADDR_W'(0), words[0]});
    for (int j = 0; j < 4; j++) send_byte(words[0][31-8*j -: 8]);
    for (int j = 0; j < 2; j++) send_byte(words[1][31-8*j -: 8]);
    byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({byte_ready, mem_we, busy, cpu_run, error} !== 5'b0 || word_count !== '0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got ready=%b we=%b busy=%b count=%0d addr=%0d data=%h, required all 0",
               byte_ready, mem_we, busy, word_count, mem_addr, mem_wdata);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL midreset_writes: got %0d pending writes, required word 0 written", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("[TB] mid-load reset released");
    load_frame(2, 8'h00, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_bad_chk();
    test_oversize();
    test_empty();
    test_gaps();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
